sample_recorder: RTL and testbench

Capture-side counterpart of the drum-kit sample player. Drains the Audio_Controller input FIFO, decimates the codec stream to the player's sample rate (one sample per DECIM clocks), and writes mono samples into the single-port sample RAM from address 0 upward. The stored clip can then be played back by the existing player. Sits between Audio_Controller (audio_in_* side) and the ram instance's write port.

---
 rtl/sample_recorder_if.sv | 30 +++
 rtl/sample_recorder.sv | 158 +++++++++++++++
 tb/tb_sample_recorder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_recorder_if.sv
// Audio-in FIFO and RAM write-port bundle for sample_recorder.
//   master: recorder side (pops the FIFO, drives the RAM write port)
//   slave : environment side (Audio_Controller FIFO plus RAM)
// Signals:
//   audio_in_available     FIFO holds an input sample
//   left/right_channel_audio_in  signed ADC samples
//   read_audio_in          FIFO pop (combinational)
//   ram_address/ram_data/ram_wren  RAM write port (registered)
interface sample_recorder_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              audio_in_available;
  logic [DATA_W-1:0] left_channel_audio_in;
  logic [DATA_W-1:0] right_channel_audio_in;
  logic              read_audio_in;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

  modport master (
    input  audio_in_available, left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, ram_address, ram_data, ram_wren
  );

  modport slave (
    output audio_in_available, left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/sample_recorder.sv
// sample_recorder: drains the audio input FIFO, keeps one sample per DECIM
// clocks and writes it into the sample RAM from address 0 up to MAX_ADDR.
// Optional build macro STEREO_MIX_EN: store (left + right) >>> 1 instead of left.
// Ports:
//   CLOCK_50   system clock (posedge)
//   resetn     asynchronous active-low reset
//   start      pulse, begin a recording at address 0 (IDLE/DONE only)
//   stop       pulse, end the recording early (ARM/CAPTURE only)
//   aud        sample_recorder_if.master: FIFO pop and RAM write port
//   busy       high in ARM and CAPTURE
//   done       high in DONE, cleared by start or reset
//   length     number of samples stored by the last recording
module sample_recorder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_ADDR = 2838,
  parameter int unsigned DECIM    = 2048,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  sample_recorder_if.master     aud,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       length
);

  localparam int unsigned CNT_W = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [LEN_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  length_q, length_d;

  logic              accept_c;
  logic              write_c;
  logic              wrap_c;
  logic [DATA_W-1:0] sample_c;

  // The FIFO is popped whenever it has data so it never backs up.
  assign accept_c          = aud.audio_in_available;
  assign aud.read_audio_in = aud.audio_in_available;

`ifdef STEREO_MIX_EN
  // Average at DATA_W+1 bits so the sum cannot overflow.
  logic [DATA_W:0] mix_c;
  assign mix_c    = {aud.left_channel_audio_in[DATA_W-1], aud.left_channel_audio_in}
                  + {aud.right_channel_audio_in[DATA_W-1], aud.right_channel_audio_in};
  assign sample_c = mix_c[DATA_W:1];
`else
  logic unused_right;
  assign unused_right = ^aud.right_channel_audio_in;
  assign sample_c     = aud.left_channel_audio_in;
`endif

  assign wrap_c = (cnt_q == CNT_W'(DECIM - 1));

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      wr_addr_q     <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      length_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      wr_addr_q     <= wr_addr_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      length_q      <= length_d;
    end
  end

  // Next-state and write decision.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    wr_addr_d     = wr_addr_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    length_d      = length_q;
    write_c       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ARM;
          wr_addr_d = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end
      S_ARM: begin
        if (accept_c) begin
          write_c = 1'b1;
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cnt_d   = wrap_c ? '0 : cnt_q + CNT_W'(1);
        write_c = accept_c && pending_q;
        // A wrap in the same cycle as a write re-arms for the next period.
        pending_d = (pending_q && !write_c) || wrap_c;
      end
      default: state_d = S_IDLE;
    endcase

    if (write_c) begin
      ram_wren_d    = 1'b1;
      ram_address_d = wr_addr_q[ADDR_W-1:0];
      ram_data_d    = sample_c;
      wr_addr_d     = wr_addr_q + LEN_W'(1);
    end

    // Finish on the write to the last address or on stop; a coincident
    // write is already included in wr_addr_d.
    if ((state_q == S_ARM || state_q == S_CAPTURE) &&
        (stop || (write_c && wr_addr_q == LEN_W'(MAX_ADDR)))) begin
      state_d  = S_DONE;
      length_d = wr_addr_d;
    end
  end

  assign busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
  assign done_d = (state_d == S_DONE);

  assign aud.ram_address = ram_address_q;
  assign aud.ram_data    = ram_data_q;
  assign aud.ram_wren    = ram_wren_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign length          = length_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder with DECIM=8, MAX_ADDR=3.
module tb_sample_recorder;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DECIM    = 8;
  localparam int unsigned MAX_ADDR = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic            stop;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] length;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     wr_addr_log[$];
  longint wr_cyc_log[$];

  always #5 clk = ~clk;

  sample_recorder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) aud ();

  sample_recorder #(
    .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR), .DECIM(DECIM), .DATA_W(DATA_W)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .start   (start),
    .stop    (stop),
    .aud     (aud),
    .busy    (busy),
    .done    (done),
    .length  (length)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log every RAM write seen on the falling edge.
  always @(negedge clk) begin
    if (aud.ram_wren) begin
      wr_addr_log.push_back(int'(aud.ram_address));
      wr_cyc_log.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected stored word for a left/right pair.
  function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] l,
                                                 input logic [DATA_W-1:0] r);
    logic [DATA_W:0] s;
`ifdef STEREO_MIX_EN
    s = {l[DATA_W-1], l} + {r[DATA_W-1], r};
    return s[DATA_W:1];
`else
    s = {1'b0, r};
    return (s[0] === 1'bx) ? l : l;
`endif
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  localparam logic [DATA_W-1:0] RIGHT = 32'h0000_0100;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    aud.audio_in_available     = 1'b0;
    aud.left_channel_audio_in  = '0;
    aud.right_channel_audio_in = RIGHT;

    // Reset values.
    #3;
    check("rst_wren", 64'(aud.ram_wren), 64'(0));
    check("rst_addr", 64'(aud.ram_address), 64'(0));
    check("rst_data", 64'(aud.ram_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_len", 64'(length), 64'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Full recording with the FIFO always non-empty.
    wr_addr_log.delete();
    wr_cyc_log.delete();
    aud.audio_in_available    = 1'b1;
    aud.left_channel_audio_in = 32'h0000_0AAA;
    check("rd_mirror", 64'(aud.read_audio_in), 64'(1));
    pulse_start();
    check("t1_busy_arm", 64'(busy), 64'(1));
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    check("t1_done_seen", 64'(done), 64'(1));
    repeat (20) @(negedge clk);
    check("t1_nwrites", 64'(wr_addr_log.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_addr%0d", i), 64'(wr_addr_log[i]), 64'(i));
    check("t1_gap12", 64'(wr_cyc_log[2] - wr_cyc_log[1]), 64'(DECIM));
    check("t1_gap23", 64'(wr_cyc_log[3] - wr_cyc_log[2]), 64'(DECIM));
    check("t1_done", 64'(done), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_len", 64'(length), 64'(4));

    // Sparse input: one write per pending period, latency and data.
    aud.audio_in_available = 1'b0;
    pulse_start();
    check("t2_done_clr", 64'(done), 64'(0));
    aud.audio_in_available    = 1'b1;
    aud.left_channel_audio_in = 32'h0000_0055;
    @(negedge clk);
    check("t2_w0_wren", 64'(aud.ram_wren), 64'(1));
    check("t2_w0_addr", 64'(aud.ram_address), 64'(0));
    check("t2_w0_data", 64'(aud.ram_data), 64'(exp_word(32'h0000_0055, RIGHT)));
    aud.audio_in_available = 1'b0;
    repeat (20) @(negedge clk);
    check("t2_idle_wren", 64'(aud.ram_wren), 64'(0));
    wr_addr_log.delete();
    aud.audio_in_available    = 1'b1;
    aud.left_channel_audio_in = 32'h0000_1234;
    @(negedge clk);
    aud.audio_in_available = 1'b0;
    check("t2_w1_wren", 64'(aud.ram_wren), 64'(1));
    check("t2_w1_addr", 64'(aud.ram_address), 64'(1));
    check("t2_w1_data", 64'(aud.ram_data), 64'(exp_word(32'h0000_1234, RIGHT)));
    @(negedge clk);
    check("t2_w1_drop", 64'(aud.ram_wren), 64'(0));
    repeat (4) @(negedge clk);
    check("t2_one_write", 64'(wr_addr_log.size()), 64'(1));

    // Early stop after two writes, then restart from address 0.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_done", 64'(done), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    check("t3_len", 64'(length), 64'(2));
    aud.audio_in_available    = 1'b1;
    aud.left_channel_audio_in = 32'hCAFE_0001;
    pulse_start();
    check("t3_done_clr", 64'(done), 64'(0));
    check("t3_busy_set", 64'(busy), 64'(1));
    @(negedge clk);
    check("t3_wren", 64'(aud.ram_wren), 64'(1));
    check("t3_addr", 64'(aud.ram_address), 64'(0));
    check("t3_data", 64'(aud.ram_data), 64'(exp_word(32'hCAFE_0001, RIGHT)));

    // Asynchronous reset in the middle of a capture.
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t4_wren", 64'(aud.ram_wren), 64'(0));
    check("t4_addr", 64'(aud.ram_address), 64'(0));
    check("t4_data", 64'(aud.ram_data), 64'(0));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_done", 64'(done), 64'(0));
    check("t4_len", 64'(length), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    wr_addr_log.delete();
    repeat (30) @(negedge clk);
    check("t4_no_write", 64'(wr_addr_log.size()), 64'(0));
    check("t4_idle", 64'(busy), 64'(0));

`ifdef STEREO_MIX_EN
    // Mixing of opposite-sign and full-scale samples.
    aud.audio_in_available = 1'b0;
    pulse_start();
    aud.audio_in_available     = 1'b1;
    aud.left_channel_audio_in  = 32'h0000_0010;
    aud.right_channel_audio_in = 32'hFFFF_FFF0;
    @(negedge clk);
    check("mix_zero", 64'(aud.ram_data), 64'(32'h0000_0000));
    stop = 1'b1;
    aud.audio_in_available = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    pulse_start();
    aud.audio_in_available     = 1'b1;
    aud.left_channel_audio_in  = 32'h7FFF_FFFF;
    aud.right_channel_audio_in = 32'h7FFF_FFFF;
    @(negedge clk);
    check("mix_max", 64'(aud.ram_data), 64'(32'h7FFF_FFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
